// File: rtl/bsg_piso_word.sv
// Parallel-in/serial-out word splitter: captures one els_p*width_p word and
// emits it as els_p chunks of width_p bits under valid/yumi handshaking.
module bsg_piso_word #(
  parameter int width_p    = 4,
  parameter int els_p      = 4,
  parameter int hi_to_lo_p = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic                       ready_and_o,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o,
  input  logic                       yumi_i
);

  localparam int cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(els_p - 1);

  typedef enum logic {
    e_idle,
    e_send
  } state_e;

  state_e                          state_r, state_n;
  logic [cnt_w_lp-1:0]             count_r, count_n;
  logic [els_p-1:0][width_p-1:0]   buf_r, buf_n;
  logic [cnt_w_lp-1:0]             idx;
  logic                            send;
  logic                            last;
  logic                            accept;

  assign send = (state_r == e_send);
  assign last = send && (count_r == last_cnt_lp);
  assign idx  = (hi_to_lo_p != 0) ? (last_cnt_lp - count_r) : count_r;

  // Taking the final chunk frees the buffer in the same cycle, so a new word
  // can be accepted without a bubble (combinational yumi_i -> ready_and_o).
  assign ready_and_o = !send || (last && yumi_i);
  assign accept      = valid_i && ready_and_o;

  assign valid_o = send;
  assign last_o  = last;
  assign data_o  = send ? buf_r[idx] : '0;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_n = state_r;
    count_n = count_r;
    buf_n   = buf_r;
    if (accept) begin
      state_n = e_send;
      count_n = '0;
      buf_n   = data_i;
    end else if (send && yumi_i) begin
      if (last) state_n = e_idle;
      else      count_n = count_r + cnt_w_lp'(1);
    end
  end

  // NOTE: the word buffer is a plain register bank, so it is cleared with the rest
  // of the state on reset; no reset-free storage is inferred here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_r <= e_idle;
      count_r <= '0;
      buf_r   <= '0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      buf_r   <= buf_n;
    end
  end

  // A consumer may only take a chunk that is actually on offer.
  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> valid_o
  );

endmodule

// File: doc/bsg_piso_word.md
BSG_PISO_WORD -- requirements
Module: bsg_piso_word

Interface
REQ-001 SHALL have parameter width_p, default 4, meaning bits per output chunk.
REQ-002 SHALL have parameter els_p, default 4, meaning chunks per input word (>=1).
REQ-003 SHALL have parameter hi_to_lo_p, default 0, meaning 0 = send chunk 0 (LSBs) first, 1 = send chunk els_p-1 (MSBs) first.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port valid_i  input  1  input word valid.
REQ-007 SHALL have port data_i  input  els_p*width_p  input word; 16 bits at defaults.
REQ-008 SHALL have port ready_and_o  output  1  block accepts data_i this cycle.
REQ-009 SHALL have port valid_o  output  1  data_o holds a valid chunk.
REQ-010 SHALL have port data_o  output  width_p  current chunk.
REQ-011 SHALL have port last_o  output  1  current chunk is the final chunk of its word.
REQ-012 SHALL have port yumi_i  input  1  consumer takes the chunk this cycle; legal only when valid_o=1.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no word held) and SEND (word held, chunks pending).
REQ-014 SHALL hold a word buffer of els_p*width_p bits and a chunk counter of ceil(log2(els_p)) bits (min 1).
REQ-015 In IDLE: ready_and_o=1, valid_o=0, last_o=0; valid_i=1 SHALL capture data_i, clear counter, go to SEND.
REQ-016 In SEND: valid_o=1; data_o = buffer chunk[count] if hi_to_lo_p=0, chunk[els_p-1-count] if hi_to_lo_p=1.
REQ-017 last_o SHALL equal (state==SEND && count==els_p-1).
REQ-018 In SEND, yumi_i=1 with last_o=0 SHALL increment counter; state unchanged.
REQ-019 In SEND, yumi_i=0 SHALL hold counter, buffer and data_o stable.
REQ-020 ready_and_o in SEND SHALL equal last_o & yumi_i (combinational path yumi_i->ready_and_o permitted).
REQ-021 In SEND, yumi_i=1 with last_o=1: if valid_i=1, capture new word, clear counter, stay in SEND (no bubble); else go to IDLE.
REQ-022 Latency: word accepted at edge N SHALL present its first chunk with valid_o=1 in cycle N+1.
REQ-023 Throughput SHALL be one chunk per cycle sustained, including across word boundaries.
REQ-024 els_p=1 SHALL work: every chunk has last_o=1; back-to-back words at one per cycle.
REQ-025 yumi_i=1 while valid_o=0 SHALL be ignored (no state change); simulation assertion SHALL flag it.
REQ-026 data_i SHALL be sampled only on acceptance; changes at other times have no effect.

Reset
REQ-027 reset_n_i=0 SHALL asynchronously force state=IDLE, counter=0, buffer=0.
REQ-028 During and after reset: valid_o=0, last_o=0, data_o=0, ready_and_o=1.
REQ-029 Reset mid-word SHALL discard remaining chunks; no chunk of that word appears after deassertion.
REQ-030 Deassertion SHALL be taken synchronously to clk_i; first acceptance possible on the first edge after deassertion.

Verification
REQ-031 Defaults, data_i=16'hA5C3 accepted, yumi_i=1 continuously -> data_o 3,C,5,A on cycles N+1..N+4, last_o=1 only with A, then valid_o=0.
REQ-032 hi_to_lo_p=1, data_i=16'hA5C3 -> data_o A,5,C,3, last_o with 3.
REQ-033 Backpressure: yumi_i=0 for 3 cycles after first chunk -> data_o held at 3, valid_o=1, ready_and_o=0 throughout; sequence resumes unchanged.
REQ-034 Back-to-back 16'h1234 then 16'hABCD, valid_i=1, yumi_i=1 -> 4,3,2,1,D,C,B,A on 8 consecutive cycles, no bubble, ready_and_o=1 in the cycle chunk 1 is taken.
REQ-035 Reset asserted after 2 of 4 chunks taken -> immediately valid_o=0, ready_and_o=1; next word 16'h00F0 -> 0,F,0,0.
REQ-036 els_p=1, width_p=16: stream of 5 words with yumi_i=1 -> each appears one cycle after acceptance, last_o=1 every cycle.
